// File: rtl/line_buf_ctrl_pkg.sv
// Shared definitions for the line-buffer write/rotation controller:
// bank geometry, FSM state encoding and the bank-to-write-enable mapping.
package line_buf_ctrl_pkg;

   localparam int NUM_BANKS  = 8;
   localparam int WIN_LINES  = 7;
   localparam int BANK_W     = 3;
   localparam int LINE_CNT_W = 11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } lb_state_e;

   // The RAM block numbers its write enables MSB-first: bank i sits on bit 7-i.
   function automatic logic [NUM_BANKS-1:0] bank_to_we(input logic [BANK_W-1:0] bank);
      logic [NUM_BANKS-1:0] we;
      we = '0;
      we[BANK_W'(NUM_BANKS-1) - bank] = 1'b1;
      return we;
   endfunction

endpackage

// File: rtl/lb_raster_cnt.sv
// Column/line raster counters with line-end, window-fill and frame-end strobes.
// A restart forces the current pixel to column 0 of line 0 before advancing.
module lb_raster_cnt #(
   parameter int H_ACTIVE  = 1920,
   parameter int V_ACTIVE  = 1080,
   parameter int ADDR_W    = 11,
   parameter int LINE_W    = 11,
   parameter int WIN_LINES = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              adv,
   input  logic              restart,
   output logic [ADDR_W-1:0] col,
   output logic [LINE_W-1:0] line_cnt,
   output logic              line_end,
   output logic              fill_end,
   output logic              frame_end
);

   logic [ADDR_W-1:0] col_q, col_d;
   logic [LINE_W-1:0] line_q, line_d, line_cur;

   always_comb begin
      col       = restart ? '0 : col_q;
      line_cur  = restart ? '0 : line_q;
      line_end  = adv && (col == ADDR_W'(H_ACTIVE - 1));
      fill_end  = line_end && (line_cur == LINE_W'(WIN_LINES - 1));
      frame_end = line_end && (line_cur == LINE_W'(V_ACTIVE - 1));
      col_d     = col_q;
      line_d    = line_q;
      if (adv) begin
         col_d  = line_end ? '0 : col + ADDR_W'(1);
         line_d = line_end ? line_cur + LINE_W'(1) : line_cur;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q  <= '0;
         line_q <= '0;
      end else begin
         col_q  <= col_d;
         line_q <= line_d;
      end
   end

   assign line_cnt = line_q;

endmodule

// File: rtl/line_buf_ctrl.sv
// Write/rotation controller for the 8-bank line-buffer RAM: writes one raster
// line per bank, rotates banks per line and flags when a 7-line window is readable.
//
// state | meaning
// IDLE  | waiting for a start-of-frame pixel
// FILL  | fewer than 7 complete lines in the buffer, window not yet valid
// RUN   | 7+ complete lines, every written pixel has a valid window
// DONE  | one cycle after the last pixel of the frame, frame_done asserted
module line_buf_ctrl
   import line_buf_ctrl_pkg::*;
#(
   parameter int H_ACTIVE = 1920,
   parameter int V_ACTIVE = 1080,
   parameter int ADDR_W   = 11,
   parameter int DATA_W   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pix_vld,
   input  logic                  pix_sof,
   input  logic [DATA_W-1:0]     pix_data,
   output logic [NUM_BANKS-1:0]  ram_ce,
   output logic [NUM_BANKS-1:0]  ram_we,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [DATA_W-1:0]     ram_wdata,
   output logic                  win_vld,
   output logic [BANK_W-1:0]     win_top,
   output logic [BANK_W-1:0]     wr_bank,
   output logic [LINE_CNT_W-1:0] line_cnt,
   output logic                  frame_done
);

   if (H_ACTIVE > (1 << ADDR_W)) begin : g_addr_chk
      $error("line_buf_ctrl: H_ACTIVE does not fit in ADDR_W address bits");
   end
   if (V_ACTIVE >= (1 << LINE_CNT_W)) begin : g_line_chk
      $error("line_buf_ctrl: V_ACTIVE does not fit in line_cnt");
   end

   lb_state_e             state_q, state_d;
   logic [BANK_W-1:0]     bank_q, bank_d, bank_cur;
   logic [NUM_BANKS-1:0]  ce_q, ce_d, we_q, we_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic                  win_q, win_d;
   logic [BANK_W-1:0]     top_q, top_d, bank_out_q, bank_out_d;
   logic                  accept, restart;
   logic [ADDR_W-1:0]     col;
   logic                  line_end, fill_end, frame_end;

   lb_raster_cnt #(
      .H_ACTIVE  (H_ACTIVE),
      .V_ACTIVE  (V_ACTIVE),
      .ADDR_W    (ADDR_W),
      .LINE_W    (LINE_CNT_W),
      .WIN_LINES (WIN_LINES)
   ) u_raster (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv       (accept),
      .restart   (restart),
      .col       (col),
      .line_cnt  (line_cnt),
      .line_end  (line_end),
      .fill_end  (fill_end),
      .frame_end (frame_end)
   );

   always_comb begin
      state_d    = state_q;
      restart    = pix_vld && pix_sof;
      accept     = pix_vld && (pix_sof || state_q == ST_FILL || state_q == ST_RUN);
      bank_cur   = restart ? '0 : bank_q;
      bank_d     = bank_q;
      we_d       = '0;
      win_d      = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      top_d      = top_q;
      bank_out_d = bank_out_q;

      case (state_q)
         ST_IDLE:         if (restart) state_d = ST_FILL;
         ST_FILL, ST_RUN: if (restart) state_d = ST_FILL;
         ST_DONE:         state_d = restart ? ST_FILL : ST_IDLE;
         default:         state_d = ST_IDLE;
      endcase

      if (accept) begin
         if (frame_end)     state_d = ST_DONE;
         else if (fill_end) state_d = ST_RUN;
         bank_d     = line_end ? bank_cur + BANK_W'(1) : bank_cur;
         we_d       = bank_to_we(bank_cur);
         win_d      = (state_q == ST_RUN) && !restart;
         addr_d     = col;
         wdata_d    = pix_data;
         top_d      = bank_cur + BANK_W'(1);
         bank_out_d = bank_cur;
      end

      // Keep the enables up through the cycle that carries the final write.
      ce_d = (state_d == ST_FILL || state_d == ST_RUN || accept) ? '1 : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         bank_q     <= '0;
         ce_q       <= '0;
         we_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         win_q      <= 1'b0;
         top_q      <= '0;
         bank_out_q <= '0;
      end else begin
         state_q    <= state_d;
         bank_q     <= bank_d;
         ce_q       <= ce_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         win_q      <= win_d;
         top_q      <= top_d;
         bank_out_q <= bank_out_d;
      end
   end

   assign ram_ce     = ce_q;
   assign ram_we     = we_q;
   assign ram_addr   = addr_q;
   assign ram_wdata  = wdata_q;
   assign win_vld    = win_q;
   assign win_top    = top_q;
   assign wr_bank    = bank_out_q;
   assign frame_done = (state_q == ST_DONE);

endmodule
